// File: rtl/c2h_axis_upsizer.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | c2h_axis_upsizer : packs narrow egress AXIS beats into wide PCIe C2H beats.   |
// | Optional counters: define C2H_UPSIZER_STATS_EN.                               |
// | Revision: 1.0                                                                 |
// +-----------------------------------------------------------------------------+
module c2h_axis_upsizer #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 256
) (
    input  logic                     user_clk_250,
    input  logic                     user_resetn_250,
    input  logic                     pcie_ready,
    input  logic [IN_WIDTH-1:0]      s_axis_tdata,
    input  logic [IN_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [OUT_WIDTH-1:0]     m_axis_tdata,
    output logic [OUT_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready
`ifdef C2H_UPSIZER_STATS_EN
    ,
    output logic [31:0]              stat_pkt_cnt,
    output logic [31:0]              stat_beat_cnt
`endif
);

    localparam int c_RATIO    = OUT_WIDTH / IN_WIDTH;
    localparam int c_IN_KEEP  = IN_WIDTH / 8;
    localparam int c_OUT_KEEP = OUT_WIDTH / 8;
    localparam int c_IDX_W    = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_RATIO - 1);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                  r_state;
    logic [c_IDX_W-1:0]      r_idx;
    logic [OUT_WIDTH-1:0]    r_buf_data;
    logic [c_OUT_KEEP-1:0]   r_buf_keep;
    logic                    r_buf_last;
    logic                    r_run;

    logic                    w_accept;
    logic                    w_complete;
    logic                    w_out_free;
    logic [OUT_WIDTH-1:0]    w_asm_data;
    logic [c_OUT_KEEP-1:0]   w_asm_keep;

    // r_run keeps tready low while reset is held and until the first clock after release.
    assign s_axis_tready = r_run & (r_state == ST_FILL) & pcie_ready;
    assign w_accept      = s_axis_tvalid & s_axis_tready;
    assign w_complete    = w_accept & ((r_idx == c_LAST_IDX) | s_axis_tlast);
    assign w_out_free    = ~m_axis_tvalid | m_axis_tready;

    // Buffer is cleared on every emission, so lanes above idx are already zero.
    always_comb begin
        w_asm_data = r_buf_data;
        w_asm_keep = r_buf_keep;
        for (int i = 0; i < c_RATIO; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_asm_data[i*IN_WIDTH +: IN_WIDTH]   = s_axis_tdata;
                w_asm_keep[i*c_IN_KEEP +: c_IN_KEEP] = s_axis_tkeep;
            end
        end
    end

    always_ff @(posedge user_clk_250 or negedge user_resetn_250) begin
        if (!user_resetn_250) begin
            r_state       <= ST_FILL;
            r_idx         <= '0;
            r_buf_data    <= '0;
            r_buf_keep    <= '0;
            r_buf_last    <= 1'b0;
            r_run         <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            case (r_state)
                ST_FILL: begin
                    if (w_complete) begin
                        if (w_out_free) begin
                            m_axis_tdata  <= w_asm_data;
                            m_axis_tkeep  <= w_asm_keep;
                            m_axis_tlast  <= s_axis_tlast;
                            m_axis_tvalid <= 1'b1;
                            r_buf_data    <= '0;
                            r_buf_keep    <= '0;
                            r_idx         <= '0;
                        end else begin
                            r_buf_data <= w_asm_data;
                            r_buf_keep <= w_asm_keep;
                            r_buf_last <= s_axis_tlast;
                            r_state    <= ST_HOLD;
                        end
                    end else if (w_accept) begin
                        r_buf_data <= w_asm_data;
                        r_buf_keep <= w_asm_keep;
                        r_idx      <= r_idx + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_out_free) begin
                        m_axis_tdata  <= r_buf_data;
                        m_axis_tkeep  <= r_buf_keep;
                        m_axis_tlast  <= r_buf_last;
                        m_axis_tvalid <= 1'b1;
                        r_buf_data    <= '0;
                        r_buf_keep    <= '0;
                        r_buf_last    <= 1'b0;
                        r_idx         <= '0;
                        r_state       <= ST_FILL;
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

`ifdef C2H_UPSIZER_STATS_EN
    always_ff @(posedge user_clk_250 or negedge user_resetn_250) begin
        if (!user_resetn_250) begin
            stat_pkt_cnt  <= '0;
            stat_beat_cnt <= '0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            stat_beat_cnt <= stat_beat_cnt + 32'd1;
            if (m_axis_tlast) begin
                stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
